// File: rtl/edge_pkg.sv
// Shared definitions for the edge/blur pipeline.
// Holds the pixel fetcher state encoding and the segment geometry constants.
// The anchor controller's x_counter steps by SEG_LEN and uses the same values.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

    // Pixels per row segment; equals the anchor x-counter increment.
    localparam int unsigned SEG_LEN    = 10;
    // Left offset of a segment relative to anchor_x.
    localparam int unsigned SEG_HALF   = 5;
    localparam int unsigned PIXEL_BITS = 8;

endpackage

// File: rtl/pixel_addr_gen.sv
// Combinational address generator for the anchor pixel fetcher.
// Computes the image column of segment slot col, decides whether that pixel
// lies outside the image (pad), and forms its SRAM address.
//   anchor_x, anchor_y : current anchor position
//   col                : segment slot, 0..SEG_LEN-1
//   width, height      : image size in pixels
//   base_addr          : SRAM address of pixel (0,0)
//   pad                : pixel is outside the image and must be zero-filled
//   mem_addr           : base_addr + anchor_y*width + px, truncated to ADDR_BITS
module pixel_addr_gen #(
    parameter int unsigned ADDR_BITS = 20,
    parameter int unsigned SEG_HALF  = edge_pkg::SEG_HALF
) (
    input  logic [15:0]          anchor_x,
    input  logic [15:0]          anchor_y,
    input  logic [3:0]           col,
    input  logic [15:0]          width,
    input  logic [15:0]          height,
    input  logic [ADDR_BITS-1:0] base_addr,
    output logic                 pad,
    output logic [ADDR_BITS-1:0] mem_addr
);

    logic [15:0] px;
    logic [31:0] row_off;

    // 16-bit wrap is intentional: anchors near the left edge give a huge px,
    // which then fails the px < width test and pads.
    assign px      = anchor_x - 16'(SEG_HALF) + 16'(col);
    assign row_off = 32'(anchor_y) * 32'(width);

    assign pad      = (anchor_y >= height) || (px >= width);
    assign mem_addr = base_addr + ADDR_BITS'(row_off) + ADDR_BITS'(px);

endmodule

// File: rtl/anchor_pixel_fetcher.sv
// Anchor pixel fetcher: for each anchor position, reads a SEG_LEN-pixel row
// segment from image SRAM and writes it into the blur row buffer, zero-padding
// pixels outside the image without touching SRAM.
//   clk, n_rst           : clock, asynchronous active-low reset
//   en_filter            : start of filter phase (honoured only in IDLE)
//   process_done         : filter phase complete, return to IDLE
//   anchor_moving        : anchor advances at the next edge (honoured in HOLD)
//   anchor_x, anchor_y   : current anchor position
//   width, height        : image size
//   base_addr            : SRAM address of pixel (0,0)
//   mem_read, mem_addr   : SRAM read request and address
//   mem_rdata, mem_ready : SRAM read data and accept/valid strobe
//   pix_we, pix_idx, pix_data : row-buffer write port
//   io_final             : segment I/O completes this cycle or is complete
module anchor_pixel_fetcher #(
    parameter int unsigned ADDR_BITS = 20,
    parameter int unsigned SEG_LEN   = edge_pkg::SEG_LEN,
    parameter int unsigned SEG_HALF  = edge_pkg::SEG_HALF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en_filter,
    input  logic                 process_done,
    input  logic                 anchor_moving,
    input  logic [15:0]          anchor_x,
    input  logic [15:0]          anchor_y,
    input  logic [15:0]          width,
    input  logic [15:0]          height,
    input  logic [ADDR_BITS-1:0] base_addr,
    output logic                 mem_read,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ready,
    output logic                 pix_we,
    output logic [3:0]           pix_idx,
    output logic [7:0]           pix_data,
    output logic                 io_final
);

    import edge_pkg::*;

    fetch_state_t         state_q, state_d;
    logic [3:0]           col_q, col_d;
    logic                 pad;
    logic [ADDR_BITS-1:0] addr;
    logic                 step_done;
    logic                 last_col;

    pixel_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .SEG_HALF  (SEG_HALF)
    ) u_addr_gen (
        .anchor_x  (anchor_x),
        .anchor_y  (anchor_y),
        .col       (col_q),
        .width     (width),
        .height    (height),
        .base_addr (base_addr),
        .pad       (pad),
        .mem_addr  (addr)
    );

    // A slot completes when padded, or when its read is accepted.
    assign step_done = (state_q == FETCH) && (pad || mem_ready);
    assign last_col  = (col_q == 4'(SEG_LEN - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (en_filter) begin
                    state_d = FETCH;
                    col_d   = '0;
                end
            end
            FETCH: begin
                if (step_done) begin
                    if (last_col) begin
                        state_d = HOLD;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (anchor_moving) begin
                    state_d = FETCH;
                    col_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
            end
        endcase
        if (process_done) begin
            state_d = IDLE;
            col_d   = '0;
        end
    end

    always_comb begin
        mem_read = 1'b0;
        mem_addr = '0;
        pix_we   = 1'b0;
        pix_idx  = '0;
        pix_data = '0;
        io_final = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!pad) begin
                    mem_read = 1'b1;
                    mem_addr = addr;
                end
                if (step_done) begin
                    pix_we   = 1'b1;
                    pix_idx  = col_q;
                    pix_data = pad ? 8'd0 : mem_rdata;
                    io_final = last_col;
                end
            end
            HOLD:    io_final = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_anchor_pixel_fetcher.sv
module tb_anchor_pixel_fetcher;

    logic        clk;
    logic        n_rst;
    logic        en_filter;
    logic        process_done;
    logic        anchor_moving;
    logic [15:0] anchor_x;
    logic [15:0] anchor_y;
    logic [15:0] width;
    logic [15:0] height;
    logic [19:0] base_addr;
    logic        mem_read;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        pix_we;
    logic [3:0]  pix_idx;
    logic [7:0]  pix_data;
    logic        io_final;

    int checks = 0;
    int errors = 0;

    anchor_pixel_fetcher dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .en_filter     (en_filter),
        .process_done  (process_done),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .width         (width),
        .height        (height),
        .base_addr     (base_addr),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .pix_we        (pix_we),
        .pix_idx       (pix_idx),
        .pix_data      (pix_data),
        .io_final      (io_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data is a fixed scramble of the low address byte.
    assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

    function automatic logic [7:0] exp_data(input logic [19:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".mem_read"}, 32'(mem_read), 0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
        chk({tag, ".pix_we"},   32'(pix_we),   0);
        chk({tag, ".pix_idx"},  32'(pix_idx),  0);
        chk({tag, ".pix_data"}, 32'(pix_data), 0);
        chk({tag, ".io_final"}, 32'(io_final), 0);
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, ".io_final"}, 32'(io_final), 1);
        chk({tag, ".mem_read"}, 32'(mem_read), 0);
        chk({tag, ".pix_we"},   32'(pix_we),   0);
    endtask

    task automatic chk_read(input string tag, input int i, input logic [19:0] a);
        chk($sformatf("%s.mem_read[%0d]", tag, i), 32'(mem_read), 1);
        chk($sformatf("%s.mem_addr[%0d]", tag, i), 32'(mem_addr), 32'(a));
        chk($sformatf("%s.pix_we[%0d]", tag, i),   32'(pix_we),   1);
        chk($sformatf("%s.pix_idx[%0d]", tag, i),  32'(pix_idx),  32'(i));
        chk($sformatf("%s.pix_data[%0d]", tag, i), 32'(pix_data), 32'(exp_data(a)));
        chk($sformatf("%s.io_final[%0d]", tag, i), 32'(io_final), (i == 9) ? 1 : 0);
    endtask

    task automatic chk_pad(input string tag, input int i);
        chk($sformatf("%s.mem_read[%0d]", tag, i), 32'(mem_read), 0);
        chk($sformatf("%s.pix_we[%0d]", tag, i),   32'(pix_we),   1);
        chk($sformatf("%s.pix_idx[%0d]", tag, i),  32'(pix_idx),  32'(i));
        chk($sformatf("%s.pix_data[%0d]", tag, i), 32'(pix_data), 0);
        chk($sformatf("%s.io_final[%0d]", tag, i), 32'(io_final), (i == 9) ? 1 : 0);
    endtask

    // Full segment of accepted reads starting at address a0.
    task automatic read_seg(input string tag, input logic [19:0] a0);
        for (int i = 0; i < 10; i++) begin
            chk_read(tag, i, a0 + 20'(i));
            next_cycle();
        end
        chk_hold({tag, ".hold"});
    endtask

    task automatic pad_seg(input string tag);
        for (int i = 0; i < 10; i++) begin
            chk_pad(tag, i);
            next_cycle();
        end
        chk_hold({tag, ".hold"});
    endtask

    // Pulse anchor_moving in HOLD; the upstream anchor updates at that edge.
    task automatic move_to(input logic [15:0] x, input logic [15:0] y);
        anchor_moving = 1'b1;
        next_cycle();
        anchor_moving = 1'b0;
        anchor_x = x;
        anchor_y = y;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst         = 1'b0;
        en_filter     = 1'b0;
        process_done  = 1'b0;
        anchor_moving = 1'b0;
        anchor_x      = 16'd5;
        anchor_y      = 16'd0;
        width         = 16'd40;
        height        = 16'd8;
        base_addr     = 20'h100;
        mem_ready     = 1'b1;
        #3;
        chk_idle("reset");
        next_cycle();
        n_rst = 1'b1;
        next_cycle();
        chk_idle("idle_no_en");

        // Anchor (5,0): px 0..9 -> 0x100..0x109.
        en_filter = 1'b1;
        next_cycle();
        en_filter = 1'b0;
        #1;
        read_seg("seg_5_0", 20'h100);
        next_cycle();
        chk_hold("hold_stays");

        // en_filter outside IDLE is ignored.
        en_filter = 1'b1;
        next_cycle();
        en_filter = 1'b0;
        #1;
        chk_hold("hold_en_ignored");

        // Anchor (35,2): 0x100 + 80 + 30.. = 0x16E..
        move_to(16'd35, 16'd2);
        read_seg("seg_35_2", 20'h16E);

        // Anchor (45,2): px 40..49 all beyond the right edge.
        move_to(16'd45, 16'd2);
        pad_seg("seg_45_2");

        // Anchor (5,9): bottom flush row.
        move_to(16'd5, 16'd9);
        pad_seg("seg_5_9");

        // Anchor (5,1) with a 3-cycle stall on col 0; addr 0x128.
        mem_ready = 1'b0;
        move_to(16'd5, 16'd1);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall.mem_read[%0d]", s), 32'(mem_read), 1);
            chk($sformatf("stall.mem_addr[%0d]", s), 32'(mem_addr), 32'h128);
            chk($sformatf("stall.pix_we[%0d]", s),   32'(pix_we),   0);
            chk($sformatf("stall.io_final[%0d]", s), 32'(io_final), 0);
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        read_seg("stall_seg", 20'h128);

        // Anchor (2,3): px wraps for cols 0..2 (pad), then reads px 0..6.
        move_to(16'd2, 16'd3);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) chk_pad("underflow", i);
            else       chk_read("underflow", i, 20'h178 + 20'(i - 3));
            next_cycle();
        end
        chk_hold("underflow.hold");

        // width=0: every pixel pads.
        width = 16'd0;
        move_to(16'd5, 16'd0);
        pad_seg("width0");
        width = 16'd40;

        // Anchor (15,0): abort with process_done on col 2.
        move_to(16'd15, 16'd0);
        chk_read("abort", 0, 20'h10A);
        next_cycle();
        chk_read("abort", 1, 20'h10B);
        process_done = 1'b1;
        next_cycle();
        process_done = 1'b0;
        #1;
        chk_idle("after_done");
        next_cycle();
        chk_idle("after_done2");

        // Reset mid-FETCH at col 4 with mem_read asserted.
        anchor_x  = 16'd5;
        anchor_y  = 16'd0;
        en_filter = 1'b1;
        next_cycle();
        en_filter = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_read("pre_rst", i, 20'h100 + 20'(i));
            next_cycle();
        end
        mem_ready = 1'b0;
        #1;
        chk("mid.mem_read", 32'(mem_read), 1);
        chk("mid.mem_addr", 32'(mem_addr), 32'h104);
        n_rst = 1'b0;
        #1;
        chk_idle("async_rst");
        next_cycle();
        n_rst     = 1'b1;
        mem_ready = 1'b1;
        next_cycle();
        chk_idle("post_rst");
        next_cycle();
        chk_idle("post_rst2");

        // Restart begins again at col 0.
        en_filter = 1'b1;
        next_cycle();
        en_filter = 1'b0;
        #1;
        read_seg("restart", 20'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
